// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode
// handshake, redirect from execute and the halted status flag.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) ();
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [4:0]         dec_opcode;
    logic [ADDR_W-1:0]  dec_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    // fetch unit side
    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_instr, dec_opcode, dec_pc,
        input  dec_ready,
        input  redirect_valid, redirect_pc,
        output halted
    );

    // memory / decode / execute side
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_instr, dec_opcode, dec_pc,
        output dec_ready,
        output redirect_valid, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order fetches, buffers the
// returned words in a small FIFO and hands them to decode in program order.
// A redirect flushes the FIFO and discards every response still in flight;
// a halt word (opcode 5'b11111) stops fetch once decode has taken it.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_HALT_PEND = 2'd1;
    localparam logic [1:0] S_HALTED    = 2'd2;
    localparam logic [4:0] HALT_OP     = 5'b11111;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fifo_entry_t;

    fifo_entry_t         fifo_mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop_cnt;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   rsp_pc;
    logic [1:0]          state;

    logic                redirect;
    logic [CW:0]         in_flight;
    logic                req_valid;
    logic                accept;
    logic                rsp_drop;
    logic                push;
    logic                halt_push;
    logic                fifo_empty;
    logic                deq_valid;
    logic                pop;
    logic                halt_pop;
    fifo_entry_t         head;
    logic [CW-1:0]       acc_inc, rsp_dec, push_inc, pop_dec;

    // handshake decisions for this cycle
    always_comb begin
        redirect   = bus.redirect_valid && (state != S_HALTED);
        in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
        req_valid  = rst_n && (state == S_RUN) && !bus.redirect_valid
                     && (in_flight < DEPTH_LIM);
        accept     = req_valid && bus.imem_req_ready;
        rsp_drop   = bus.imem_rsp_valid && (drop_cnt != '0);
        // responses younger than a halt, or hit by a redirect, never enter the FIFO
        push       = bus.imem_rsp_valid && (drop_cnt == '0) && (state == S_RUN)
                     && !redirect;
        halt_push  = push && (bus.imem_rsp_data[INSTR_W-1 -: 5] == HALT_OP);
        fifo_empty = (fifo_count == '0);
        head       = fifo_mem[rd_ptr];
        deq_valid  = !fifo_empty && !bus.redirect_valid && (state != S_HALTED);
        pop        = deq_valid && bus.dec_ready;
        halt_pop   = pop && (state == S_HALT_PEND)
                     && (head.instr[INSTR_W-1 -: 5] == HALT_OP);
        acc_inc    = {{(CW-1){1'b0}}, accept};
        rsp_dec    = {{(CW-1){1'b0}}, bus.imem_rsp_valid};
        push_inc   = {{(CW-1){1'b0}}, push};
        pop_dec    = {{(CW-1){1'b0}}, pop};
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc;
    assign bus.dec_valid      = deq_valid;
    // an empty FIFO presents zeros rather than stale storage
    assign bus.dec_instr      = fifo_empty ? '0 : head.instr;
    assign bus.dec_pc         = fifo_empty ? '0 : head.pc;
    assign bus.dec_opcode     = bus.dec_instr[INSTR_W-1 -: 5];
    assign bus.halted         = (state == S_HALTED);

    // FIFO storage: write-only, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{instr: bus.imem_rsp_data, pc: rsp_pc};
        end
    end

    // PC, response tracking, FIFO pointers and fetch state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= S_RUN;
        end else begin
            outstanding <= outstanding + acc_inc - rsp_dec;

            if (redirect) begin
                pc         <= bus.redirect_pc;
                rsp_pc     <= bus.redirect_pc;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                // outstanding already counts words still owed to an earlier
                // flush, so everything in flight (minus this cycle's arrival)
                // becomes the new discard budget
                drop_cnt   <= outstanding - rsp_dec;
            end else begin
                if (accept)   pc       <= pc + ADDR_W'(1);
                if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + ADDR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + push_inc - pop_dec;
            end

            case (state)
                S_RUN:       if (halt_push) state <= S_HALT_PEND;
                S_HALT_PEND: begin
                    if (redirect)      state <= S_RUN;
                    else if (halt_pop) state <= S_HALTED;
                end
                S_HALTED:    state <= S_HALTED;
                default:     state <= S_RUN;
            endcase
        end
    end
endmodule
